// File: rtl/robertsons_arbiter.sv
// Round-robin arbiter/sequencer sharing one Robertson's multiplier among
// NREQ requesters: range-checks operands, starts the multiplier, waits for
// done (with timeout) and returns the signed product to the winner.
module robertsons_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_multiplier,
    input  logic [8*NREQ-1:0]   req_multiplicand,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     resp_valid,
    output logic [15:0]         resp_product,
    output logic                resp_err,
    output logic                busy,
    output logic                mul_start,
    output logic [7:0]          mul_multiplier,
    output logic [7:0]          mul_multiplicand,
    input  logic [15:0]         mul_product,
    input  logic                mul_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        BUSY,
        RESP,
        REJECT
    } state_t;

    state_t          state_q, state_n;
    logic [PW-1:0]   ptr_q, ptr_n;
    logic [PW-1:0]   owner_q, owner_n;
    logic [CW-1:0]   cnt_q, cnt_n;

    logic [NREQ-1:0] grant_n, resp_valid_n;
    logic [15:0]     resp_product_n;
    logic            resp_err_n, busy_n, mul_start_n;
    logic [7:0]      mpr_n, mpd_n;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [7:0]      win_mpr, win_mpd;

    function automatic logic in_range(input logic [7:0] v);
        logic signed [7:0] s;
        s = v;
        return (s >= -8'sd64) && (s <= 8'sd63);
    endfunction

    // Round-robin pick: scan a doubled index window starting at ptr so the
    // wrap-around needs no modular addition on the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_mpr   = '0;
        win_mpd   = '0;
        for (int unsigned i = 0; i < 2 * NREQ; i++) begin
            if (!win_found && (i >= 32'(ptr_q)) && req[PW'(i % NREQ)]) begin
                win_found = 1'b1;
                win_idx   = PW'(i % NREQ);
                win_mpr   = req_multiplier[8*(i % NREQ) +: 8];
                win_mpd   = req_multiplicand[8*(i % NREQ) +: 8];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n        = state_q;
        ptr_n          = ptr_q;
        owner_n        = owner_q;
        cnt_n          = cnt_q;
        grant_n        = '0;
        resp_valid_n   = '0;
        resp_product_n = resp_product;
        resp_err_n     = resp_err;
        mul_start_n    = 1'b0;
        mpr_n          = mul_multiplier;
        mpd_n          = mul_multiplicand;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_n          = win_idx;
                    grant_n[win_idx] = 1'b1;
                    if (in_range(win_mpr) && in_range(win_mpd)) begin
                        mpr_n       = win_mpr;
                        mpd_n       = win_mpd;
                        mul_start_n = 1'b1;
                        state_n     = START;
                    end else begin
                        resp_valid_n[win_idx] = 1'b1;
                        resp_product_n        = '0;
                        resp_err_n            = 1'b1;
                        state_n               = REJECT;
                    end
                end
            end
            START: begin
                cnt_n   = '0;
                state_n = SETTLE;
            end
            SETTLE: begin
                state_n = BUSY;
            end
            BUSY: begin
                if (mul_done) begin
                    resp_product_n        = mul_product;
                    resp_err_n            = 1'b0;
                    resp_valid_n[owner_q] = 1'b1;
                    state_n               = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_product_n        = '0;
                    resp_err_n            = 1'b1;
                    resp_valid_n[owner_q] = 1'b1;
                    state_n               = RESP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RESP, REJECT: begin
                ptr_n   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            ptr_q            <= '0;
            owner_q          <= '0;
            cnt_q            <= '0;
            grant            <= '0;
            resp_valid       <= '0;
            resp_product     <= '0;
            resp_err         <= 1'b0;
            busy             <= 1'b0;
            mul_start        <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
        end else begin
            state_q          <= state_n;
            ptr_q            <= ptr_n;
            owner_q          <= owner_n;
            cnt_q            <= cnt_n;
            grant            <= grant_n;
            resp_valid       <= resp_valid_n;
            resp_product     <= resp_product_n;
            resp_err         <= resp_err_n;
            busy             <= busy_n;
            mul_start        <= mul_start_n;
            mul_multiplier   <= mpr_n;
            mul_multiplicand <= mpd_n;
        end
    end

endmodule

// File: tb/tb_robertsons_arbiter.sv
// Self-checking bench for robertsons_arbiter: cycle-stepped requester model,
// behavioural multiplier emulation and a transaction-level expectation model.
module tb_robertsons_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 40;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   req_multiplier;
    logic [8*NREQ-1:0]   req_multiplicand;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     resp_valid;
    logic [15:0]         resp_product;
    logic                resp_err;
    logic                busy;
    logic                mul_start;
    logic [7:0]          mul_multiplier;
    logic [7:0]          mul_multiplicand;
    logic [15:0]         mul_product;
    logic                mul_done;

    robertsons_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_multiplier   (req_multiplier),
        .req_multiplicand (req_multiplicand),
        .grant            (grant),
        .resp_valid       (resp_valid),
        .resp_product     (resp_product),
        .resp_err         (resp_err),
        .busy             (busy),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_done         (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // requester / transaction model state
    bit [NREQ-1:0] pend;
    int            opa [NREQ];
    int            opb [NREQ];
    int            posted [NREQ];
    int            seen_rv [NREQ];
    int            rr_ptr;
    bit            in_txn;
    bit            resp_last;
    int            t_idx, t_grant, resp_at;
    logic [15:0]   e_prod;
    logic          e_err;
    int            cyc;
    int            fixed_lat;
    int            cur_lat;
    // multiplier emulation
    int            mt;
    logic [15:0]   mprod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit inr(input int v);
        return (v >= -64) && (v <= 63);
    endfunction

    task automatic post(input int r, input int a, input int b);
        pend[r] = 1'b1;
        opa[r]  = a;
        opb[r]  = b;
        req[r]  = 1'b1;
        req_multiplier[8*r +: 8]   = 8'(a);
        req_multiplicand[8*r +: 8] = 8'(b);
        posted[r]++;
    endtask

    task automatic model_reset();
        in_txn    = 1'b0;
        resp_last = 1'b0;
        pend      = '0;
        req       = '0;
        rr_ptr    = 0;
        mt        = -1;
        mul_done  = 1'b0;
        for (int r = 0; r < NREQ; r++) posted[r] = seen_rv[r];
    endtask

    // Behavioural multiplier: done/product stay stale through START and the
    // following cycle, then done rises after cur_lat BUSY cycles.
    task automatic mul_emulate();
        int ma, mb;
        if (mul_start === 1'b1) begin
            ma    = int'($signed(mul_multiplier));
            mb    = int'($signed(mul_multiplicand));
            mprod = 16'(ma * mb);
            mt    = 0;
        end else if (mt >= 0) begin
            mt++;
        end
        if (mt >= 2) begin
            if (mt - 2 >= cur_lat) begin
                mul_done    = 1'b1;
                mul_product = mprod;
            end else begin
                mul_done    = 1'b0;
                mul_product = 16'($urandom);
            end
        end
    endtask

    // One clock cycle: predict, advance, compare all outputs, drive multiplier.
    task automatic tick();
        bit due, ok, resp_now;
        int didx, lat, ta, tbv;
        logic [NREQ-1:0] exp_g, exp_rv;
        due  = 1'b0;
        didx = 0;
        if (!in_txn && !resp_last) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx = (rr_ptr + k) % NREQ;
                if (!due && pend[idx]) begin
                    due  = 1'b1;
                    didx = idx;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_g = '0;
        ok    = 1'b0;
        if (due) begin
            exp_g[didx] = 1'b1;
            in_txn  = 1'b1;
            t_idx   = didx;
            t_grant = cyc;
            ta      = opa[didx];
            tbv     = opb[didx];
            pend[didx] = 1'b0;
            req[didx]  = 1'b0;
            ok  = inr(ta) && inr(tbv);
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            cur_lat = lat;
            if (!ok) begin
                resp_at = cyc; e_prod = '0; e_err = 1'b1;
            end else if (lat < TIMEOUT) begin
                resp_at = cyc + 3 + lat; e_prod = 16'(ta * tbv); e_err = 1'b0;
            end else begin
                resp_at = cyc + 2 + TIMEOUT; e_prod = '0; e_err = 1'b1;
            end
        end
        chk("grant", 32'(grant), 32'(exp_g));
        chk("mul_start", 32'(mul_start), 32'(due && ok));
        chk("busy", 32'(busy), 32'(in_txn));
        exp_rv   = '0;
        resp_now = 1'b0;
        if (in_txn && cyc == resp_at) begin
            exp_rv[t_idx] = 1'b1;
            resp_now      = 1'b1;
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        for (int r = 0; r < NREQ; r++) if (resp_valid[r] === 1'b1) seen_rv[r]++;
        if (resp_now) begin
            chk("resp_product", 32'(resp_product), 32'(e_prod));
            chk("resp_err", 32'(resp_err), 32'(e_err));
            in_txn = 1'b0;
            rr_ptr = (t_idx + 1) % NREQ;
        end
        resp_last = resp_now;
        mul_emulate();
    endtask

    task automatic drain(input int bound);
        bit quiet = 1'b0;
        for (int i = 0; i < bound && !quiet; i++) begin
            tick();
            quiet = !in_txn && (pend == '0) && !resp_last;
        end
        chk("drain_done", 32'(quiet), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"},      32'(grant),            32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid),       32'd0);
        chk({tag, "_resp_prod"},  32'(resp_product),     32'd0);
        chk({tag, "_resp_err"},   32'(resp_err),         32'd0);
        chk({tag, "_busy"},       32'(busy),             32'd0);
        chk({tag, "_mul_start"},  32'(mul_start),        32'd0);
        chk({tag, "_mul_mpr"},    32'(mul_multiplier),   32'd0);
        chk({tag, "_mul_mpd"},    32'(mul_multiplicand), 32'd0);
    endtask

    initial begin
        int bl [10];
        int n;
        bit hit;
        bl = '{-64, -63, -2, -1, 0, 1, 2, 62, 63, 0};
        req = '0; req_multiplier = '0; req_multiplicand = '0;
        mul_product = '0; mul_done = 1'b0;
        for (int r = 0; r < NREQ; r++) begin posted[r] = 0; seen_rv[r] = 0; end
        cyc = 0; fixed_lat = 2; cur_lat = 0; mprod = '0;
        t_idx = 0; t_grant = 0; resp_at = 0; e_prod = '0; e_err = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        model_reset();
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;

        // single request 5 x 6
        post(0, 5, 6);
        drain(100);

        // all four at once, then 0 and 2 re-raised while 3 is in flight
        fixed_lat = 1;
        post(0, 7, -5); post(1, -5, 6); post(2, -7, 8); post(3, -9, -4);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            hit = in_txn && (t_idx == 3);
        end
        chk("wait_grant3", 32'(hit), 32'd1);
        post(2, 11, 3);
        post(0, -12, 5);
        drain(200);

        // range boundaries and rejects
        fixed_lat = 0;
        post(1, 5, -65);
        drain(50);
        post(2, -64, 63);
        drain(50);
        post(3, 64, 1);
        drain(50);

        // timeout and the done-wins-on-last-cycle boundary
        fixed_lat = 1000;
        post(1, 3, 4);
        drain(200);
        fixed_lat = TIMEOUT - 1;
        post(2, 3, 4);
        drain(200);
        fixed_lat = TIMEOUT;
        post(0, -3, 4);
        drain(200);

        // asynchronous reset in the middle of BUSY
        fixed_lat = 20;
        post(0, 10, 10);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            tick();
            hit = in_txn && (cyc >= t_grant + 3);
        end
        chk("reach_busy", 32'(hit), 32'd1);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
        fixed_lat = 1;
        post(2, 63, -64);
        drain(100);

        // randomized sweep on rotating requesters
        fixed_lat = -1;
        n = 0;
        for (int a = -64; a <= 63; a++) begin
            for (int j = 0; j < 10; j++) begin
                int r, b;
                r = n % NREQ;
                b = (j == 9) ? int'($urandom_range(0, 127)) - 64 : bl[j];
                if (n % 37 == 36)
                    b = ($urandom_range(0, 1) == 1) ? 64 + int'($urandom_range(0, 63))
                                                    : -65 - int'($urandom_range(0, 63));
                for (int w = 0; w < 200 && pend[r]; w++) tick();
                post(r, a, b);
                n++;
            end
        end
        drain(500);

        for (int r = 0; r < NREQ; r++) chk($sformatf("resp_count%0d", r), 32'(seen_rv[r]), 32'(posted[r]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
